// File: rtl/aes_pkg.sv
// Shared AES definitions for the ShiftRows/MixColumns round stage:
// GF(2^8) helpers, byte/column indexing and the FSM state type.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam logic [7:0]  AES_RED = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
    endfunction

    // Byte k in FIPS-197 column-major order: s[127-8k -: 8].
    function automatic logic [7:0] aes_byte(input logic [STATE_W-1:0] s, input logic [3:0] k);
        return 8'(s >> {4'd15 - k, 3'b000});
    endfunction

endpackage

// File: rtl/aes_shift_mix_if.sv
// State-in / state-out valid-ready channels of the ShiftRows/MixColumns stage.
interface aes_shift_mix_if;

    logic [aes_pkg::STATE_W-1:0] s_in;
    logic                        s_in_last;
    logic                        s_in_valid;
    logic                        s_in_ready;
    logic [aes_pkg::STATE_W-1:0] s_out;
    logic                        s_out_valid;
    logic                        s_out_ready;

    modport slave (
        input  s_in, s_in_last, s_in_valid, s_out_ready,
        output s_in_ready, s_out, s_out_valid
    );

    modport master (
        output s_in, s_in_last, s_in_valid, s_out_ready,
        input  s_in_ready, s_out, s_out_valid
    );

endinterface

// File: rtl/aes_mix_column.sv
// Combinational AES MixColumns on a single 32-bit column (row 0 in the MSB byte).
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign {a0, a1, a2, a3} = col_i;
    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3a = 2a ^ a
    assign col_o = {
        x0 ^ (x1 ^ a1) ^ a2 ^ a3,
        a0 ^ x1 ^ (x2 ^ a2) ^ a3,
        a0 ^ a1 ^ x2 ^ (x3 ^ a3),
        (x0 ^ a0) ^ a1 ^ a2 ^ x3
    };

endmodule

// File: rtl/aes_shift_mix.sv
// Iterative ShiftRows + MixColumns: one output column per cycle, MixColumns
// bypassed on the final round, result held under backpressure.
module aes_shift_mix
    import aes_pkg::*;
(
    input logic           clk,
    input logic           rst,
    aes_shift_mix_if.slave io
);

    aes_state_e         state_q;
    logic [1:0]         col_q;
    logic               last_q;
    logic [STATE_W-1:0] in_q;
    logic [STATE_W-1:0] out_q;
    logic [STATE_W-1:0] out_d;
    logic               out_valid_q;

    logic               accept_c;
    logic [COL_W-1:0]   shifted_col_c;
    logic [COL_W-1:0]   mixed_col_c;
    logic [COL_W-1:0]   col_res_c;

    assign io.s_in_ready = !rst && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_DONE) && io.s_out_ready));
    assign accept_c      = io.s_in_valid && io.s_in_ready;
    assign io.s_out       = out_q;
    assign io.s_out_valid = out_valid_q;

    // Output column col_q, row r comes from input column (col_q + r) mod 4.
    always_comb begin
        shifted_col_c = '0;
        for (int r = 0; r < 4; r++) begin
            shifted_col_c[31 - 8*r -: 8] = aes_byte(in_q, {col_q + 2'(r), 2'(r)});
        end
    end

    aes_mix_column u_mix (
        .col_i (shifted_col_c),
        .col_o (mixed_col_c)
    );

    assign col_res_c = last_q ? shifted_col_c : mixed_col_c;

    always_comb begin
        out_d = out_q;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                out_d[127 - 32*c -: 32] = col_res_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= 2'd0;
            last_q      <= 1'b0;
            in_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        in_q    <= io.s_in;
                        last_q  <= io.s_in_last;
                        col_q   <= 2'd0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    out_q <= out_d;
                    if (col_q == 2'd3) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        col_q <= col_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    // Result consumed; a same-cycle accept restarts with no bubble.
                    if (io.s_out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept_c) begin
                            in_q    <= io.s_in;
                            last_q  <= io.s_in_last;
                            col_q   <= 2'd0;
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_shift_mix.sv
// Self-checking bench for aes_shift_mix against a byte-array AES round model.
module tb_aes_shift_mix;

    localparam logic [127:0] FIPS_IN   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] FIPS_MIX  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] FIPS_LAST = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    aes_shift_mix_if bus ();

    aes_shift_mix dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // General GF(2^8) product (shift-and-add, reduced by 0x11B).
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   u [16];
        logic [127:0] res;
        for (int k = 0; k < 16; k++) a[k] = s[127 - 8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = a[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            u[4*c+0] = gmul(8'd2, t[4*c]) ^ gmul(8'd3, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
            u[4*c+1] = t[4*c] ^ gmul(8'd2, t[4*c+1]) ^ gmul(8'd3, t[4*c+2]) ^ t[4*c+3];
            u[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'd2, t[4*c+2]) ^ gmul(8'd3, t[4*c+3]);
            u[4*c+3] = gmul(8'd3, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'd2, t[4*c+3]);
        end
        res = '0;
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = last ? t[k] : u[k];
        return res;
    endfunction

    // Present a state and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [127:0] d, input logic l, output int ok);
        bus.s_in       = d;
        bus.s_in_last  = l;
        bus.s_in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.s_in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.s_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.s_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pop();
        bus.s_out_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.s_out_valid); end
        checks++; if (bus.s_out !== 128'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.s_out); end
        checks++; if (bus.s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", bus.s_in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.s_in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", bus.s_in_ready); end
    endtask

    task automatic test_fips(input logic last, input logic [127:0] exp, input string name);
        int ok, n;
        send(FIPS_IN, last, ok);
        checks++; if (ok !== 1) begin errors++; $display("FAIL %s_accept: got %0d expected 1", name, ok); end
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, n); end
        checks++; if (bus.s_out !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, bus.s_out, exp); end
        checks++; if (bus.s_out !== ref_round(FIPS_IN, last)) begin errors++; $display("FAIL %s_model: got %h expected %h", name, bus.s_out, ref_round(FIPS_IN, last)); end
        pop();
        checks++; if (bus.s_out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b expected 0", name, bus.s_out_valid); end
    endtask

    task automatic test_columns();
        logic [31:0] cin  [3];
        logic [31:0] cexp [3];
        int ok, n;
        cin[0] = 32'hdb135345; cexp[0] = 32'h8e4da1bc;
        cin[1] = 32'hf20a225c; cexp[1] = 32'h9fdc589d;
        cin[2] = 32'h01010101; cexp[2] = 32'h01010101;
        for (int i = 0; i < 3; i++) begin
            send({4{cin[i]}}, 1'b0, ok);
            wait_valid(n);
            checks++;
            if (bus.s_out !== {4{cexp[i]}}) begin
                errors++;
                $display("FAIL column_%0d: got %h expected %h", i, bus.s_out, {4{cexp[i]}});
            end
            pop();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, ea, eb;
        logic la, lb;
        int ok, n;
        a = {$urandom, $urandom, $urandom, $urandom}; la = 1'($urandom_range(0, 1));
        b = {$urandom, $urandom, $urandom, $urandom}; lb = 1'($urandom_range(0, 1));
        ea = ref_round(a, la);
        eb = ref_round(b, lb);
        send(a, la, ok);
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency_a: got %0d expected 4", n); end
        bus.s_in = b; bus.s_in_last = lb; bus.s_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.s_out !== ea) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, bus.s_out, ea); end
            checks++; if (bus.s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.s_out_valid); end
            checks++; if (bus.s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, bus.s_in_ready); end
            @(posedge clk); #1;
        end
        bus.s_out_ready = 1'b1;
        #1;
        checks++; if (bus.s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.s_in_ready); end
        @(posedge clk); #1;
        bus.s_out_ready = 1'b0;
        bus.s_in_valid  = 1'b0;
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency_b: got %0d expected 4", n); end
        checks++; if (bus.s_out !== eb) begin errors++; $display("FAIL bp_data_b: got %h expected %h", bus.s_out, eb); end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [127:0] q [$];
        logic [127:0] e;
        int sent, got, cyc, last_acc;
        logic acc, fire;
        sent = 0; got = 0; cyc = 0; last_acc = -1;
        bus.s_in       = {$urandom, $urandom, $urandom, $urandom};
        bus.s_in_last  = 1'($urandom_range(0, 1));
        bus.s_in_valid = 1'b1;
        bus.s_out_ready = 1'b1;
        #1;
        while (got < 8 && cyc < 200) begin
            acc  = bus.s_in_valid && bus.s_in_ready;
            fire = bus.s_out_valid && bus.s_out_ready;
            if (fire) begin
                e = q.pop_front();
                checks++;
                if (bus.s_out !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, bus.s_out, e); end
                got++;
            end
            if (acc) begin
                q.push_back(ref_round(bus.s_in, bus.s_in_last));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 5) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected 5", sent, cyc - last_acc); end
                end
                last_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < 8) begin
                    bus.s_in      = {$urandom, $urandom, $urandom, $urandom};
                    bus.s_in_last = 1'($urandom_range(0, 1));
                end else begin
                    bus.s_in_valid = 1'b0;
                end
            end
        end
        checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
        bus.s_in_valid  = 1'b0;
        bus.s_out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int ok, n;
        send(FIPS_IN, 1'b0, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.s_out[127:96] !== 32'h046681e5) begin errors++; $display("FAIL ar_partial_col0: got %h expected 046681e5", bus.s_out[127:96]); end
        rst = 1'b1;
        #1;
        checks++; if (bus.s_out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus.s_out_valid); end
        checks++; if (bus.s_out !== 128'h0) begin errors++; $display("FAIL ar_out: got %h expected 0", bus.s_out); end
        checks++; if (bus.s_in_ready !== 1'b0) begin errors++; $display("FAIL ar_ready: got %b expected 0", bus.s_in_ready); end
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (bus.s_out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_stale: got %b expected 0", bus.s_out_valid); end
        test_fips(1'b0, FIPS_MIX, "ar_fips");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.s_in        = '0;
        bus.s_in_last   = 1'b0;
        bus.s_in_valid  = 1'b0;
        bus.s_out_ready = 1'b0;
        test_reset();
        test_fips(1'b0, FIPS_MIX, "fips_mix");
        test_fips(1'b1, FIPS_LAST, "fips_last");
        test_columns();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
